// File: rtl/bsg_wormhole_concentrator_in_stamped.sv
// Concentrates num_in_p wormhole links onto one link with packet-level round-robin
// arbitration and optional header cid stamping. `BSG_WORMHOLE_CONC_IN_PERF_EN adds pkt_count_o.
module bsg_wormhole_concentrator_in_stamped #(
  parameter int unsigned flit_width_p = 16,
  parameter int unsigned len_width_p  = 4,
  parameter int unsigned cid_width_p  = 2,
  parameter int unsigned cord_width_p = 4,
  parameter int unsigned num_in_p     = 4,
  parameter int unsigned fifo_els_p   = 2,
  parameter int unsigned stamp_cid_p  = 1
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_in_p-1:0]              links_v_i,
  input  logic [num_in_p*flit_width_p-1:0] links_data_i,
  output logic [num_in_p-1:0]              links_ready_and_rev_o,
  input  logic                             concentrated_link_ready_and_rev_i,
  output logic                             concentrated_link_v_o,
  output logic [flit_width_p-1:0]          concentrated_link_data_o
`ifdef BSG_WORMHOLE_CONC_IN_PERF_EN
  , output logic [num_in_p*32-1:0]         pkt_count_o
`endif
);

  localparam int unsigned idx_w   = (num_in_p > 1) ? $clog2(num_in_p) : 1;
  localparam int unsigned ptr_w   = $clog2(fifo_els_p);
  localparam int unsigned cnt_w   = $clog2(fifo_els_p + 1);
  localparam int unsigned len_lsb = cord_width_p;
  localparam int unsigned cid_lsb = cord_width_p + len_width_p;

  typedef enum logic {ST_UNLOCKED, ST_LOCKED} arb_state_e;

  logic [flit_width_p-1:0] mem    [num_in_p][fifo_els_p];
  logic [ptr_w-1:0]        rd_ptr [num_in_p];
  logic [ptr_w-1:0]        wr_ptr [num_in_p];
  logic [cnt_w-1:0]        count  [num_in_p];
  logic                    ready_en;
  logic [num_in_p-1:0]     fifo_v, enq, deq;

  arb_state_e              state;
  logic [idx_w-1:0]        lock_idx, rr_ptr, rr_sel, sel, hold_idx;
  logic                    hold_v, found, send;
  logic [len_width_p-1:0]  cnt, head_len;
  logic [flit_width_p-1:0] head;
  int unsigned             rr_j;

  // Ready is purely occupancy based, held low until the first edge after reset.
  always_comb begin
    for (int unsigned i = 0; i < num_in_p; i++) begin
      fifo_v[i]                = (count[i] != '0);
      links_ready_and_rev_o[i] = ready_en && (count[i] != cnt_w'(fifo_els_p));
      enq[i]                   = links_v_i[i] && links_ready_and_rev_o[i];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < num_in_p; i++)
      deq[i] = send && (sel == idx_w'(i));
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < num_in_p; i++)
      if (enq[i]) mem[i][wr_ptr[i]] <= links_data_i[i*flit_width_p +: flit_width_p];
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < num_in_p; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < num_in_p; i++) begin
        if (enq[i])
          wr_ptr[i] <= (wr_ptr[i] == ptr_w'(fifo_els_p - 1)) ? '0 : wr_ptr[i] + ptr_w'(1);
        if (deq[i])
          rd_ptr[i] <= (rd_ptr[i] == ptr_w'(fifo_els_p - 1)) ? '0 : rd_ptr[i] + ptr_w'(1);
        count[i] <= count[i] + cnt_w'(enq[i]) - cnt_w'(deq[i]);
      end
    end
  end

  // While unlocked every input sits at a header, so any non-empty FIFO is a candidate.
  always_comb begin
    found  = 1'b0;
    rr_sel = '0;
    rr_j   = 0;
    for (int unsigned k = 0; k < num_in_p; k++) begin
      rr_j = (32'(rr_ptr) + k) % num_in_p;
      if (!found && fifo_v[idx_w'(rr_j)]) begin
        found  = 1'b1;
        rr_sel = idx_w'(rr_j);
      end
    end
  end

  always_comb begin
    if (state == ST_LOCKED) sel = lock_idx;
    else if (hold_v)        sel = hold_idx;
    else                    sel = rr_sel;
  end

  assign concentrated_link_v_o = (state == ST_LOCKED || hold_v) ? fifo_v[sel] : found;
  assign send     = concentrated_link_v_o && concentrated_link_ready_and_rev_i;
  assign head     = mem[sel][rd_ptr[sel]];
  assign head_len = head[len_lsb +: len_width_p];

  if (stamp_cid_p != 0 && cid_width_p > 0) begin : g_stamp
    always_comb begin
      concentrated_link_data_o = head;
      if (state == ST_UNLOCKED)
        concentrated_link_data_o[cid_lsb +: cid_width_p] = cid_width_p'(sel);
    end
  end else begin : g_pass
    assign concentrated_link_data_o = head;
  end

  // Packet lock; a stalled offered header is pinned so the output stays stable.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= ST_UNLOCKED;
      lock_idx <= '0;
      rr_ptr   <= '0;
      cnt      <= '0;
      hold_v   <= 1'b0;
      hold_idx <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        ST_UNLOCKED: begin
          if (send) begin
            hold_v <= 1'b0;
            rr_ptr <= (sel == idx_w'(num_in_p - 1)) ? '0 : sel + idx_w'(1);
            if (head_len != '0) begin
              state    <= ST_LOCKED;
              lock_idx <= sel;
              cnt      <= head_len;
            end
          end else if (concentrated_link_v_o) begin
            hold_v   <= 1'b1;
            hold_idx <= sel;
          end
        end
        ST_LOCKED: begin
          if (send) begin
            cnt <= cnt - len_width_p'(1);
            if (cnt == len_width_p'(1)) state <= ST_UNLOCKED;
          end
        end
        default: state <= ST_UNLOCKED;
      endcase
    end
  end

`ifdef BSG_WORMHOLE_CONC_IN_PERF_EN
  logic        tail_send;
  logic [31:0] pkt_cnt [num_in_p];

  assign tail_send = send && ((state == ST_UNLOCKED && head_len == '0) ||
                              (state == ST_LOCKED && cnt == len_width_p'(1)));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < num_in_p; i++) pkt_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < num_in_p; i++)
        if (tail_send && sel == idx_w'(i)) pkt_cnt[i] <= pkt_cnt[i] + 32'(1);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < num_in_p; i++) pkt_count_o[i*32 +: 32] = pkt_cnt[i];
  end
`endif

endmodule

// File: tb/tb_bsg_wormhole_concentrator_in_stamped.sv
// Randomized bench for bsg_wormhole_concentrator_in_stamped against a packet-level queue model.
module tb_bsg_wormhole_concentrator_in_stamped;

  localparam int N  = 4;
  localparam int FW = 16;

  logic            clk = 1'b0;
  logic            reset_i = 1'b1;
  logic [N-1:0]    links_v;
  logic [N*FW-1:0] links_data;
  logic [N-1:0]    links_ready;
  logic            out_ready;
  logic            out_v;
  logic [FW-1:0]   out_data;
`ifdef BSG_WORMHOLE_CONC_IN_PERF_EN
  logic [N*32-1:0] pkt_count;
`endif

  always #5 clk = ~clk;

  bsg_wormhole_concentrator_in_stamped #(
    .flit_width_p(FW), .len_width_p(4), .cid_width_p(2), .cord_width_p(4),
    .num_in_p(N), .fifo_els_p(2), .stamp_cid_p(1)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .links_v_i(links_v),
    .links_data_i(links_data),
    .links_ready_and_rev_o(links_ready),
    .concentrated_link_ready_and_rev_i(out_ready),
    .concentrated_link_v_o(out_v),
    .concentrated_link_data_o(out_data)
`ifdef BSG_WORMHOLE_CONC_IN_PERF_EN
    , .pkt_count_o(pkt_count)
`endif
  );

  // Flits the sources still want to send, and flits the DUT holds per input.
  logic [FW-1:0] src_q [N][$];
  logic [FW-1:0] mq    [N][$];
  bit m_locked, m_hold, m_ready_en;
  int m_lock, m_cnt, m_ptr, m_hold_idx;
  int m_pkts [N];
  int acc [N];
  int out_flits = 0, in_flits = 0;
  int vpct = 100, rpct = 100;
  int checks = 0, failures = 0;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      src_q[i].delete();
      m_pkts[i] = 0;
    end
    m_locked = 0; m_hold = 0; m_ready_en = 0;
    m_lock = 0; m_cnt = 0; m_ptr = 0; m_hold_idx = 0;
  endtask

  task automatic push_pkt(input int i, input int len, input int cord);
    logic [FW-1:0] f;
    f = FW'($urandom);
    f[3:0] = 4'(cord);
    f[7:4] = 4'(len);
    src_q[i].push_back(f);
    for (int b = 0; b < len; b++) src_q[i].push_back(FW'($urandom));
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++)
      if (src_q[i].size() != 0 || mq[i].size() != 0) return 0;
    return 1;
  endfunction

  // One clock: drive, check at negedge, advance the model at posedge.
  task automatic step();
    int src, j;
    bit exp_v;
    bit exp_rdy [N];
    logic [FW-1:0] exp_d, f;
    for (int i = 0; i < N; i++) begin
      links_v[i] = (src_q[i].size() > 0) && ($urandom_range(99) < vpct);
      links_data[i*FW +: FW] = (src_q[i].size() > 0) ? src_q[i][0] : FW'($urandom);
    end
    out_ready = ($urandom_range(99) < rpct);
    @(negedge clk);
    src = -1;
    if (m_locked) begin
      if (mq[m_lock].size() > 0) src = m_lock;
    end else if (m_hold) begin
      src = m_hold_idx;
    end else begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (src < 0 && mq[j].size() > 0) src = j;
      end
    end
    exp_v = (src >= 0);
    checks++;
    if (out_v !== exp_v) begin
      failures++;
      $display("FAIL out_v t=%0t got=%b exp=%b", $time, out_v, exp_v);
    end
    if (exp_v) begin
      exp_d = mq[src][0];
      if (!m_locked) exp_d[9:8] = 2'(src);
      checks++;
      if (out_data !== exp_d) begin
        failures++;
        $display("FAIL out_data t=%0t src=%0d got=%h exp=%h", $time, src, out_data, exp_d);
      end
    end
    for (int i = 0; i < N; i++) begin
      exp_rdy[i] = m_ready_en && (mq[i].size() < 2);
      checks++;
      if (links_ready[i] !== exp_rdy[i]) begin
        failures++;
        $display("FAIL ready[%0d] t=%0t got=%b exp=%b", i, $time, links_ready[i], exp_rdy[i]);
      end
    end
    @(posedge clk);
    if (exp_v && out_ready) begin
      f = mq[src].pop_front();
      out_flits++;
      if (!m_locked) begin
        m_hold = 0;
        m_ptr = (src + 1) % N;
        if (f[7:4] != 4'd0) begin
          m_locked = 1; m_lock = src; m_cnt = int'(f[7:4]);
        end else m_pkts[src]++;
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin m_locked = 0; m_pkts[src]++; end
      end
    end else if (exp_v && !m_locked) begin
      m_hold = 1; m_hold_idx = src;
    end
    for (int i = 0; i < N; i++)
      if (links_v[i] && exp_rdy[i]) begin
        mq[i].push_back(src_q[i].pop_front());
        acc[i]++;
        in_flits++;
      end
    m_ready_en = 1;
    #1;
  endtask

  task automatic drain(input string name, input int max_cycles);
    for (int c = 0; c < max_cycles && !all_empty(); c++) step();
    checks++;
    if (!all_empty()) begin
      failures++;
      $display("FAIL drain_%s got=not_empty exp=empty", name);
    end
  endtask

  task automatic check_count(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset_i = 1; links_v = '0; links_data = '0; out_ready = 1;
    model_reset();
    #12;
    checks += 2;
    if (out_v !== 1'b0) begin failures++; $display("FAIL reset_v got=%b exp=0", out_v); end
    if (links_ready !== '0) begin failures++; $display("FAIL reset_ready got=%b exp=0", links_ready); end
    @(posedge clk); #1;
    reset_i = 0;
    step();
    step();
  endtask

  task automatic test_single_flit();
    int base = out_flits;
    push_pkt(0, 0, 5);
    drain("single", 20);
    check_count("single_out_flits", out_flits - base, 1);
  endtask

  task automatic test_long_packet();
    int base = out_flits;
    push_pkt(2, 3, $urandom_range(15));
    drain("long", 30);
    check_count("long_out_flits", out_flits - base, 4);
  endtask

  task automatic test_two_inputs();
    int base = out_flits;
    push_pkt(0, 1, $urandom_range(15));
    push_pkt(1, 1, $urandom_range(15));
    drain("two", 30);
    check_count("two_out_flits", out_flits - base, 4);
  endtask

  task automatic test_stall();
    int base = out_flits;
    logic [FW-1:0] tail;
    push_pkt(0, 2, $urandom_range(15));
    tail = src_q[0].pop_back();
    for (int c = 0; c < 4; c++) step();
    push_pkt(3, 0, $urandom_range(15));
    for (int c = 0; c < 3; c++) step();
    check_count("stall_locked_out_flits", out_flits - base, 2);
    src_q[0].push_back(tail);
    drain("stall", 30);
    check_count("stall_out_flits", out_flits - base, 4);
  endtask

  task automatic test_backpressure();
    int base = out_flits;
    for (int i = 0; i < N; i++) begin
      acc[i] = 0;
      push_pkt(i, 6, $urandom_range(15));
      push_pkt(i, 6, $urandom_range(15));
    end
    rpct = 0;
    for (int c = 0; c < 10; c++) step();
    for (int i = 0; i < N; i++) check_count($sformatf("bp_accepted_%0d", i), acc[i], 2);
    rpct = 100;
    drain("bp", 200);
    check_count("bp_out_flits", out_flits - base, 56);
  endtask

  task automatic test_reset_mid();
    int base = out_flits;
    push_pkt(1, 5, $urandom_range(15));
    for (int c = 0; c < 20 && out_flits < base + 2; c++) step();
    check_count("mid_sent_before_reset", out_flits - base, 2);
    #3;
    reset_i = 1;
    #1;
    checks += 2;
    if (out_v !== 1'b0) begin failures++; $display("FAIL mid_reset_v got=%b exp=0", out_v); end
    if (links_ready !== '0) begin failures++; $display("FAIL mid_reset_ready got=%b exp=0", links_ready); end
    model_reset();
    @(posedge clk); #1;
    reset_i = 0;
    base = out_flits;
    push_pkt(3, 0, $urandom_range(15));
    push_pkt(1, 0, $urandom_range(15));
    drain("after_reset", 30);
    check_count("after_reset_out_flits", out_flits - base, 2);
  endtask

  task automatic test_random();
    int base_out = out_flits, base_in = in_flits;
    vpct = 70; rpct = 60;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if (src_q[i].size() < 4 && $urandom_range(9) < 3)
          push_pkt(i, ($urandom_range(7) == 0) ? 15 : $urandom_range(15), $urandom_range(15));
      step();
    end
    vpct = 100; rpct = 100;
    drain("random", 600);
    check_count("random_in_vs_out", out_flits - base_out, in_flits - base_in);
`ifdef BSG_WORMHOLE_CONC_IN_PERF_EN
    for (int i = 0; i < N; i++)
      check_count($sformatf("pkt_count_%0d", i), int'(pkt_count[i*32 +: 32]), m_pkts[i]);
`endif
  endtask

  initial begin
    test_reset();
    test_single_flit();
    test_long_packet();
    test_two_inputs();
    test_stall();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
